// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch pipeline: word width, bubble encoding,
// default reset PC and the fetch-stage state encoding.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        HELD    = 2'd2,
        DISCARD = 2'd3
    } if_state_e;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Flush wins over load; flush keeps PC_ID so a
// bubble still reports the last real instruction address.
module if_id_reg
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instr_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instr_o,
    output logic            valid_o
);
    logic [XLEN-1:0] pc_d, pc_q;
    logic [XLEN-1:0] instr_d, instr_q;
    logic            valid_d, valid_q;

    // next-value selection: flush, load or hold
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end else if (load_i) begin
            pc_d    = pc_i;
            instr_d = instr_i;
            valid_d = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // register state with asynchronous reset to a bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= {XLEN{1'b0}};
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    assign pc_o    = pc_q;
    assign instr_o = instr_q;
    assign valid_o = valid_q;
endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem request handshake, one-entry stall
// buffer and discard of fetches made stale by an EX redirect.
module if_stage
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            STALL_ID,
    input  logic            PCSrc_EX,
    input  logic [XLEN-1:0] PC_BRANCH_EX,
    output logic [XLEN-1:0] PC_IF,
    output logic [XLEN-1:0] PC_ID,
    output logic [XLEN-1:0] INSTRUCTION_ID,
    output logic            VALID_ID
);
    if_state_e       state_d, state_q;
    logic [XLEN-1:0] pc_d, pc_q;
    logic [XLEN-1:0] buf_d, buf_q;
    logic [XLEN-1:0] disc_addr_d, disc_addr_q;
    logic            req_d, req_q;
    logic [XLEN-1:0] addr_d, addr_q;
    logic            ld_s, fl_s;
    logic [XLEN-1:0] ld_instr_s;

    // next-state, PC and IF/ID control; redirect outranks stall and ack
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        buf_d       = buf_q;
        disc_addr_d = disc_addr_q;
        ld_s        = 1'b0;
        fl_s        = 1'b0;
        ld_instr_s  = imem_rdata;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                if (PCSrc_EX) begin
                    fl_s = 1'b1;
                    pc_d = PC_BRANCH_EX;
                end else begin
                    fl_s = 1'b0;
                end
            end
            FETCH: begin
                if (PCSrc_EX) begin
                    fl_s = 1'b1;
                    pc_d = PC_BRANCH_EX;
                    if (imem_ack) begin
                        state_d = FETCH;
                    end else begin
                        // request cannot be withdrawn; finish it at the old address
                        disc_addr_d = pc_q;
                        state_d     = DISCARD;
                    end
                end else if (imem_ack && !STALL_ID) begin
                    ld_s = 1'b1;
                    pc_d = pc_q + 32'd4;
                end else if (imem_ack) begin
                    buf_d   = imem_rdata;
                    state_d = HELD;
                end else begin
                    fl_s = !STALL_ID;
                end
            end
            HELD: begin
                if (PCSrc_EX) begin
                    fl_s    = 1'b1;
                    pc_d    = PC_BRANCH_EX;
                    state_d = FETCH;
                end else if (!STALL_ID) begin
                    ld_s       = 1'b1;
                    ld_instr_s = buf_q;
                    pc_d       = pc_q + 32'd4;
                    state_d    = FETCH;
                end else begin
                    state_d = HELD;
                end
            end
            DISCARD: begin
                fl_s = 1'b1;
                if (PCSrc_EX) begin
                    pc_d = PC_BRANCH_EX;
                end else begin
                    pc_d = pc_q;
                end
                if (imem_ack) begin
                    state_d = FETCH;
                end else begin
                    state_d = DISCARD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        req_d  = (state_d == FETCH) || (state_d == DISCARD);
        addr_d = (state_d == DISCARD) ? disc_addr_d : pc_d;
    end

    // fetch state registers; reset drops imem_req without waiting for a clock
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            buf_q       <= {XLEN{1'b0}};
            disc_addr_q <= {XLEN{1'b0}};
            req_q       <= 1'b0;
            addr_q      <= RESET_PC;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            buf_q       <= buf_d;
            disc_addr_q <= disc_addr_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
        end
    end

    if_id_reg #(.NOP_INSTR(NOP_INSTR)) u_if_id (
        .clk     (clk),
        .reset   (reset),
        .load_i  (ld_s),
        .flush_i (fl_s),
        .pc_i    (pc_q),
        .instr_i (ld_instr_s),
        .pc_o    (PC_ID),
        .instr_o (INSTRUCTION_ID),
        .valid_o (VALID_ID)
    );

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign PC_IF     = pc_q;
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed reset/zero-wait/async-reset steps plus a
// randomized stretch checked cycle by cycle against a behavioural model.
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        STALL_ID;
    logic        PCSrc_EX;
    logic [31:0] PC_BRANCH_EX;
    logic [31:0] PC_IF;
    logic [31:0] PC_ID;
    logic [31:0] INSTRUCTION_ID;
    logic        VALID_ID;

    int errors = 0;
    int checks = 0;

    // behavioural model: a fetcher with at most one request in flight
    logic        m_started, m_has_buf, m_discarding;
    logic [31:0] m_pc, m_buf, m_disc_addr;
    logic [31:0] m_pcid, m_ins;
    logic        m_val;

    always #5 clk = ~clk;

    if_stage dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .STALL_ID(STALL_ID), .PCSrc_EX(PCSrc_EX), .PC_BRANCH_EX(PC_BRANCH_EX),
        .PC_IF(PC_IF), .PC_ID(PC_ID), .INSTRUCTION_ID(INSTRUCTION_ID),
        .VALID_ID(VALID_ID)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0; m_has_buf = 1'b0; m_discarding = 1'b0;
        m_pc = 32'h0; m_buf = 32'h0; m_disc_addr = 32'h0;
        m_pcid = 32'h0; m_ins = NOP; m_val = 1'b0;
    endtask

    task automatic bubble();
        m_ins = NOP;
        m_val = 1'b0;
    endtask

    task automatic deliver(input logic [31:0] word);
        m_pcid = m_pc;
        m_ins  = word;
        m_val  = 1'b1;
        m_pc   = m_pc + 32'd4;
    endtask

    task automatic model_step(input logic ack, input logic stall, input logic br,
                              input logic [31:0] tgt, input logic [31:0] rd);
        if (!m_started) begin
            m_started = 1'b1;
            if (br) begin bubble(); m_pc = tgt; end
        end else if (br) begin
            bubble();
            if (m_discarding) begin
                if (ack) m_discarding = 1'b0;
            end else if (m_has_buf) begin
                m_has_buf = 1'b0;
            end else if (!ack) begin
                m_discarding = 1'b1;
                m_disc_addr  = m_pc;
            end
            m_pc = tgt;
        end else if (m_discarding) begin
            bubble();
            if (ack) m_discarding = 1'b0;
        end else if (m_has_buf) begin
            if (!stall) begin deliver(m_buf); m_has_buf = 1'b0; end
        end else if (ack) begin
            if (stall) begin m_buf = rd; m_has_buf = 1'b1; end
            else deliver(rd);
        end else if (!stall) begin
            bubble();
        end
    endtask

    task automatic compare_all();
        logic exp_req;
        exp_req = m_started && !m_has_buf;
        chk("imem_req", {31'd0, imem_req}, {31'd0, exp_req});
        if (imem_req && exp_req)
            chk("imem_addr", imem_addr, m_discarding ? m_disc_addr : m_pc);
        chk("PC_IF", PC_IF, m_pc);
        chk("PC_ID", PC_ID, m_pcid);
        chk("INSTRUCTION_ID", INSTRUCTION_ID, m_ins);
        chk("VALID_ID", {31'd0, VALID_ID}, {31'd0, m_val});
    endtask

    // one clock: drive inputs, advance the model, sample 1 time unit after the edge
    task automatic cycle(input logic ack, input logic stall, input logic br,
                         input logic [31:0] tgt, input logic [31:0] rd);
        imem_ack = ack; STALL_ID = stall; PCSrc_EX = br;
        PC_BRANCH_EX = tgt; imem_rdata = rd;
        model_step(ack && imem_req, stall, br, tgt, rd);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic check_reset_values();
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_PC_IF", PC_IF, 32'h0);
        chk("rst_PC_ID", PC_ID, 32'h0);
        chk("rst_INSTRUCTION_ID", INSTRUCTION_ID, NOP);
        chk("rst_VALID_ID", {31'd0, VALID_ID}, 32'd0);
    endtask

    initial begin
        int guard;
        logic ack_r;
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
        STALL_ID = 1'b0; PCSrc_EX = 1'b0; PC_BRANCH_EX = 32'h0;
        model_reset();
        #1;
        check_reset_values();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("first_cycle_req", {31'd0, imem_req}, 32'd0);

        // zero-wait memory: ack tied high, rdata = addr + 0x100
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 1'b0, 1'b0, 32'h0, imem_addr + 32'h100);
        chk("zero_wait_pc_id", PC_ID, 32'h18);
        chk("zero_wait_instr", INSTRUCTION_ID, 32'h118);

        // randomized latency, stalls and redirects (including misaligned targets)
        for (int i = 0; i < 600; i++) begin
            ack_r = imem_req && ($urandom_range(0, 2) != 0);
            cycle(ack_r, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
                  $urandom, $urandom);
        end

        // wait for an outstanding request, then reset between clock edges
        guard = 0;
        while (!imem_req && guard < 20) begin
            cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            guard++;
        end
        chk("req_before_async_reset", {31'd0, imem_req}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check_reset_values();
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
        chk("restart_first_cycle_req", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 1'b0, 1'b0, 32'h0, imem_addr + 32'h100);
        chk("restart_pc_id", PC_ID, 32'h8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
